// File: rtl/trace_dump.sv
// Streams a captured trace from the circular sample RAM to the UART, oldest sample first.
// The walk covers every RAM address exactly once and ends with a one-cycle dump_fin pulse.
module trace_dump #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump,
    input  logic [ADDR_W-1:0] trace_end,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_trmt,
    input  logic              tx_done,
    output logic              busy,
    output logic              dump_fin
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAT,
        WAITTX,
        FIN
    } state_t;

    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

    state_t            state_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              ram_en_q;
    logic              tx_trmt_q;
    logic              busy_q;
    logic              dump_fin_q;

    // Oldest sample sits just past the last written one; wraps naturally at ADDR_W bits.
    logic [ADDR_W-1:0] start_addr_d;
    logic [ADDR_W-1:0] next_addr_d;
    assign start_addr_d = trace_end + 1'b1;
    assign next_addr_d  = ram_addr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            ram_en_q   <= 1'b0;
            tx_trmt_q  <= 1'b0;
            busy_q     <= 1'b0;
            dump_fin_q <= 1'b0;
        end else begin
            ram_en_q   <= 1'b0;
            tx_trmt_q  <= 1'b0;
            dump_fin_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dump) begin
                        ram_addr_q <= start_addr_d;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        ram_en_q   <= 1'b1;
                        state_q    <= RD;
                    end
                end
                RD: state_q <= LAT;
                LAT: begin
                    tx_data_q <= ram_rdata;
                    tx_trmt_q <= 1'b1;
                    state_q   <= WAITTX;
                end
                WAITTX: begin
                    if (tx_done) begin
                        cnt_q      <= cnt_q + 1'b1;
                        ram_addr_q <= next_addr_d;
                        if (cnt_q == LAST_CNT) begin
                            dump_fin_q <= 1'b1;
                            state_q    <= FIN;
                        end else begin
                            ram_en_q <= 1'b1;
                            state_q  <= RD;
                        end
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_en   = ram_en_q;
    assign tx_data  = tx_data_q;
    assign tx_trmt  = tx_trmt_q;
    assign busy     = busy_q;
    assign dump_fin = dump_fin_q;

endmodule

// File: tb/tb_trace_dump.sv
// Bench for trace_dump: RAM and UART models, expected stream computed from the trace ordering rule.
module tb_trace_dump;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int N  = 512;

    logic          clk = 1'b0;
    logic          rst, dump, tx_done;
    logic [AW-1:0] trace_end, ram_addr;
    logic          ram_en, tx_trmt, busy, dump_fin;
    logic [DW-1:0] ram_rdata, tx_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mem[N];

    trace_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .dump(dump), .trace_end(trace_end),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_trmt(tx_trmt), .tx_done(tx_done),
        .busy(busy), .dump_fin(dump_fin)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM; garbage on non-read cycles exposes wrong sampling times.
    always @(posedge clk) ram_rdata <= ram_en ? DW'(mem[ram_addr]) : DW'($urandom);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ram_en"}, 32'(ram_en), 0);
        chk({tag, "_trmt"}, 32'(tx_trmt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fin"}, 32'(dump_fin), 0);
    endtask

    // mode: 0 = tx_done 5 cycles after tx_trmt, 1 = random 0..6, 2 = same cycle
    task automatic run_dump(input int te, input int mode, input int dup_at,
                            input int abort_at, input bit dump_at_fin);
        int nrd = 0, ntx = 0, nfin = 0, ref_c, done_at = 0, last_done = 0, fin_c = 0;
        int cur = 0;
        bit pend = 0, dup_done = 0, fell = 0;
        @(negedge clk);
        trace_end = AW'(te);
        dump      = 1'b1;
        ref_c     = cyc;
        for (int b = 0; b < N * 12 + 50; b++) begin
            step();
            dump    = 1'b0;
            tx_done = 1'b0;
            if (ram_en) begin
                if (nrd < N) chk("rd_addr", 32'(ram_addr), (te + 1 + nrd) % N);
                else chk("rd_count", nrd + 1, N);
                nrd++;
            end
            if (tx_trmt) begin
                chk("trmt_lat", cyc, ref_c + 3);
                cur = mem[(te + 1 + ntx) % N];
                chk("tx_data", 32'(tx_data), cur);
                ntx++;
                pend    = 1'b1;
                done_at = cyc + (mode == 0 ? 5 : mode == 1 ? int'($urandom_range(0, 6)) : 0);
            end else if (pend) begin
                chk("tx_hold", 32'(tx_data), cur);
            end
            if (dump_fin) begin
                nfin++;
                fin_c = cyc;
                chk("fin_lat", cyc, last_done + 1);
                chk("fin_addr", 32'(ram_addr), (te + 1) % N);
                chk("fin_busy", 32'(busy), 1);
                if (dump_at_fin) dump = 1'b1;
            end
            if (!busy) begin
                if (nfin == 0) chk("busy_early", 0, 1);
                else begin
                    chk("busy_fall", cyc, fin_c + 1);
                    fell = 1'b1;
                end
                break;
            end
            if (pend && cyc == done_at) begin
                tx_done   = 1'b1;
                pend      = 1'b0;
                ref_c     = cyc;
                last_done = cyc;
            end
            if (dup_at >= 0 && ntx == dup_at && !dup_done) begin
                dump     = 1'b1;
                dup_done = 1'b1;
            end
            if (abort_at >= 0 && ntx == abort_at) begin
                rst = 1'b1;
                step();
                rst     = 1'b0;
                tx_done = 1'b0;
                dump    = 1'b0;
                chk("abort_nofin", nfin, 0);
                return;
            end
        end
        chk("n_rd", nrd, N);
        chk("n_tx", ntx, N);
        chk("n_fin", nfin, 1);
        chk("busy_fell", 32'(fell), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            dump    = 1'b0;
            tx_done = 1'b0;
            chk_quiet("post");
        end
    endtask

    initial begin
        rst = 1'b1; dump = 1'b0; tx_done = 1'b0; trace_end = '0;
        repeat (3) step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_quiet("idle");
            chk("idle_addr", 32'(ram_addr), 0);
            chk("idle_txd", 32'(tx_data), 0);
        end

        for (int i = 0; i < N; i++) mem[i] = i & 255;
        run_dump(32'h0FF, 0, -1, -1, 1'b0);

        for (int i = 0; i < N; i++) mem[i] = int'($urandom_range(0, 255));
        run_dump(32'h1FF, 1, -1, -1, 1'b0);
        run_dump(32'h000, 0, -1, -1, 1'b0);
        run_dump(int'($urandom_range(0, N - 1)), 2, -1, -1, 1'b0);
        run_dump(int'($urandom_range(0, N - 1)), 1, 37, -1, 1'b1);
        run_dump(int'($urandom_range(0, N - 1)), 1, -1, 100, 1'b0);

        // Stray tx_done after the abort must not wake anything up.
        step();
        chk_quiet("abort");
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_quiet("stray");
        end
        run_dump(32'h010, 0, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
